// File: rtl/hdlc_rx_frame_ctrl.sv
// Receive-side HDLC frame controller: flag hunt, zero-bit deletion, abort detection,
// byte assembly and frame delimiting on a per-bit strobed serial input.
module hdlc_rx_frame_ctrl #(
  parameter int unsigned MIN_BYTES = 4,
  parameter int unsigned LEN_W     = 16
) (
  input  logic             Clk,
  input  logic             Rstn,
  input  logic             En,
  input  logic             SRX,
  output logic [7:0]       RxData,
  output logic             RxValid,
  output logic             RxSof,
  output logic             RxEof,
  output logic [LEN_W-1:0] RxLen,
  output logic             RxErr,
  output logic [1:0]       RxErrCode,
  output logic             RxActive
);

  typedef enum logic [1:0] {HUNT, SYNC, FRAME} state_t;

  localparam logic [1:0] ERR_ABORT = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_SHORT = 2'd3;

  state_t           state;
  logic [7:0]       win;
  logic [3:0]       ones;
  logic [7:0]       shift_q;
  logic [2:0]       bit_cnt;
  logic [7:0]       hold_q;
  logic             hold_v;
  logic [LEN_W-1:0] byte_cnt;
  logic             sof_pend;

  logic [7:0]       win_n;
  logic [3:0]       ones_n;
  logic             flag_c;
  logic             abort_c;
  logic             data_c;
  logic [7:0]       byte_c;
  logic             byte_done_c;
  logic [LEN_W-1:0] byte_cnt_inc;

  // Per-bit classification from the incoming bit and the previous run of ones.
  always_comb begin
    win_n        = {SRX, win[7:1]};
    ones_n       = SRX ? ((ones == 4'd15) ? ones : ones + 4'd1) : 4'd0;
    flag_c       = En && (win_n == 8'h7E);
    abort_c      = En && (ones_n == 4'd7);
    data_c       = En && (ones <= 4'd4);
    byte_c       = {SRX, shift_q[7:1]};
    byte_done_c  = data_c && (bit_cnt == 3'd7);
    byte_cnt_inc = (byte_cnt == {LEN_W{1'b1}}) ? byte_cnt : byte_cnt + LEN_W'(1);
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state     <= HUNT;
      win       <= 8'd0;
      ones      <= 4'd0;
      shift_q   <= 8'd0;
      bit_cnt   <= 3'd0;
      hold_q    <= 8'd0;
      hold_v    <= 1'b0;
      byte_cnt  <= '0;
      sof_pend  <= 1'b0;
      RxData    <= 8'd0;
      RxValid   <= 1'b0;
      RxSof     <= 1'b0;
      RxEof     <= 1'b0;
      RxLen     <= '0;
      RxErr     <= 1'b0;
      RxErrCode <= 2'd0;
      RxActive  <= 1'b0;
    end else begin
      RxValid <= 1'b0;
      RxSof   <= 1'b0;
      RxEof   <= 1'b0;
      RxErr   <= 1'b0;
      if (En) begin
        win  <= win_n;
        ones <= ones_n;
        if (data_c && (state != HUNT)) begin
          shift_q <= byte_c;
          bit_cnt <= bit_cnt + 3'd1;
        end
        case (state)
          HUNT: begin
            if (flag_c) begin
              state   <= SYNC;
              bit_cnt <= 3'd0;
              hold_v  <= 1'b0;
            end
          end
          SYNC: begin
            if (abort_c) begin
              state <= HUNT;
            end else if (flag_c) begin
              bit_cnt <= 3'd0;
            end else if (byte_done_c) begin
              state    <= FRAME;
              hold_q   <= byte_c;
              hold_v   <= 1'b1;
              byte_cnt <= LEN_W'(1);
              sof_pend <= 1'b1;
              RxActive <= 1'b1;
            end
          end
          FRAME: begin
            if (abort_c) begin
              state     <= HUNT;
              hold_v    <= 1'b0;
              RxErr     <= 1'b1;
              RxErrCode <= ERR_ABORT;
              RxActive  <= 1'b0;
            end else if (flag_c) begin
              state    <= SYNC;
              bit_cnt  <= 3'd0;
              hold_v   <= 1'b0;
              RxActive <= 1'b0;
              // Aligned close leaves exactly the flag's six leading bits in the assembler.
              if ((bit_cnt == 3'd6) && hold_v) begin
                RxValid <= 1'b1;
                RxData  <= hold_q;
                RxSof   <= sof_pend;
                RxEof   <= 1'b1;
                RxLen   <= byte_cnt;
                if (byte_cnt < LEN_W'(MIN_BYTES)) begin
                  RxErr     <= 1'b1;
                  RxErrCode <= ERR_SHORT;
                end
              end else begin
                RxErr     <= 1'b1;
                RxErrCode <= ERR_ALIGN;
              end
            end else if (byte_done_c) begin
              hold_q   <= byte_c;
              hold_v   <= 1'b1;
              byte_cnt <= byte_cnt_inc;
              if (hold_v) begin
                RxValid  <= 1'b1;
                RxData   <= hold_q;
                RxSof    <= sof_pend;
                sof_pend <= 1'b0;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// Self-checking bench: frames are built as stuffed bit streams, expected output events
// are derived from the frame description (byte list, termination kind).
module tb_hdlc_rx_frame_ctrl;
  localparam int unsigned MIN_BYTES = 4;
  localparam int unsigned LEN_W     = 16;

  logic             Clk = 1'b0;
  logic             Rstn, En, SRX;
  logic [7:0]       RxData;
  logic             RxValid, RxSof, RxEof, RxErr, RxActive;
  logic [LEN_W-1:0] RxLen;
  logic [1:0]       RxErrCode;

  hdlc_rx_frame_ctrl #(.MIN_BYTES(MIN_BYTES), .LEN_W(LEN_W)) dut (
    .Clk(Clk), .Rstn(Rstn), .En(En), .SRX(SRX),
    .RxData(RxData), .RxValid(RxValid), .RxSof(RxSof), .RxEof(RxEof),
    .RxLen(RxLen), .RxErr(RxErr), .RxErrCode(RxErrCode), .RxActive(RxActive)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic             v;
    logic [7:0]       data;
    logic             sof;
    logic             eof;
    logic [LEN_W-1:0] len;
    logic             err;
    logic [1:0]       code;
  } ev_t;

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  ev_t        mon_e;
  bit         bits_q[$];
  logic [7:0] fb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         stuff_ones = 0;
  int         bad_strobes = 0;
  int         gap_max = 3;
  logic       en_q = 1'b0;

  // Output event capture; a strobe is only legal right after an En cycle.
  always @(posedge Clk) en_q <= En;
  always @(negedge Clk) begin
    if (RxValid || RxErr) begin
      mon_e.v    = RxValid;
      mon_e.data = RxValid ? RxData : 8'd0;
      mon_e.sof  = RxValid ? RxSof : 1'b0;
      mon_e.eof  = RxValid ? RxEof : 1'b0;
      mon_e.len  = (RxValid && RxEof) ? RxLen : '0;
      mon_e.err  = RxErr;
      mon_e.code = RxErr ? RxErrCode : 2'd0;
      obs_q.push_back(mon_e);
      if (!en_q) bad_strobes++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_flag();
    bit f[8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    foreach (f[i]) bits_q.push_back(f[i]);
  endtask

  task automatic push_stuffed(input bit b);
    bits_q.push_back(b);
    if (b) begin
      stuff_ones++;
      if (stuff_ones == 5) begin
        bits_q.push_back(1'b0);
        stuff_ones = 0;
      end
    end else begin
      stuff_ones = 0;
    end
  endtask

  task automatic add_bytes();
    logic [7:0] b;
    stuff_ones = 0;
    foreach (fb_q[i]) begin
      b = fb_q[i];
      for (int j = 0; j < 8; j++) push_stuffed(b[j]);
    end
  endtask

  task automatic send_bits();
    while (bits_q.size() > 0) begin
      @(negedge Clk);
      En  = 1'b1;
      SRX = bits_q.pop_front();
      @(negedge Clk);
      En = 1'b0;
      repeat ($urandom_range(0, gap_max)) @(negedge Clk);
    end
  endtask

  task automatic exp_data(input int n, input bit last_eof);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      e.v    = 1'b1;
      e.data = fb_q[i];
      e.sof  = (i == 0);
      e.eof  = last_eof && (i == n - 1);
      e.len  = e.eof ? LEN_W'(n) : '0;
      e.err  = e.eof && (n < int'(MIN_BYTES));
      e.code = e.err ? 2'd3 : 2'd0;
      exp_q.push_back(e);
    end
  endtask

  task automatic exp_err(input logic [1:0] code);
    ev_t e;
    e.v = 1'b0; e.data = 8'd0; e.sof = 1'b0; e.eof = 1'b0; e.len = '0;
    e.err = 1'b1; e.code = code;
    exp_q.push_back(e);
  endtask

  task automatic check_events(input string tag);
    int n;
    repeat (3) @(negedge Clk);
    #1;
    chk($sformatf("%s.count", tag), obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d].valid", tag, i), obs_q[i].v, exp_q[i].v);
      chk($sformatf("%s[%0d].data", tag, i), obs_q[i].data, exp_q[i].data);
      chk($sformatf("%s[%0d].sof", tag, i), obs_q[i].sof, exp_q[i].sof);
      chk($sformatf("%s[%0d].eof", tag, i), obs_q[i].eof, exp_q[i].eof);
      chk($sformatf("%s[%0d].len", tag, i), obs_q[i].len, exp_q[i].len);
      chk($sformatf("%s[%0d].err", tag, i), obs_q[i].err, exp_q[i].err);
      chk($sformatf("%s[%0d].code", tag, i), obs_q[i].code, exp_q[i].code);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic seg_good(input string tag, input int nflags);
    repeat (nflags) add_flag();
    add_bytes();
    send_bits();
    chk({tag, ".active"}, RxActive, 1'b1);
    add_flag();
    send_bits();
    exp_data(fb_q.size(), 1'b1);
    check_events(tag);
    chk({tag, ".idle"}, RxActive, 1'b0);
  endtask

  // Abort: every completed byte but the held one is delivered, then code 1.
  task automatic seg_abort(input string tag);
    add_flag();
    add_bytes();
    repeat (7) bits_q.push_back(1'b1);
    send_bits();
    exp_data(fb_q.size() - 1, 1'b0);
    exp_err(2'd1);
    check_events(tag);
    chk({tag, ".idle"}, RxActive, 1'b0);
  endtask

  // Misaligned close: data bits total 8k+e plus the flag's six leading bits.
  task automatic seg_misalign(input string tag, input int e);
    int done;
    add_flag();
    add_bytes();
    for (int i = 0; i < e; i++) push_stuffed(1'($urandom_range(0, 1)));
    add_flag();
    send_bits();
    done = (8 * fb_q.size() + e + 6) / 8;
    exp_data(done - 1, 1'b0);
    exp_err(2'd2);
    check_events(tag);
  endtask

  task automatic rand_bytes(input int n);
    fb_q.delete();
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0:       fb_q.push_back(8'hFF);
        1:       fb_q.push_back(8'h7E);
        default: fb_q.push_back(8'($urandom_range(0, 255)));
      endcase
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".RxData"}, RxData, 8'd0);
    chk({tag, ".RxValid"}, RxValid, 1'b0);
    chk({tag, ".RxSof"}, RxSof, 1'b0);
    chk({tag, ".RxEof"}, RxEof, 1'b0);
    chk({tag, ".RxLen"}, RxLen, '0);
    chk({tag, ".RxErr"}, RxErr, 1'b0);
    chk({tag, ".RxErrCode"}, RxErrCode, 2'd0);
    chk({tag, ".RxActive"}, RxActive, 1'b0);
  endtask

  initial begin
    Rstn = 1'b0; En = 1'b0; SRX = 1'b0;
    repeat (3) @(negedge Clk);
    chk_reset_outputs("reset");
    Rstn = 1'b1;

    fb_q = '{8'h03, 8'h3F, 8'hA5, 8'h5A};
    seg_good("basic", 1);
    fb_q = '{8'h01, 8'hFF, 8'hFF, 8'h02};
    seg_good("stuffed", 1);
    fb_q = '{8'h11, 8'h22};
    seg_abort("abort");
    add_flag(); add_flag();
    send_bits();
    check_events("post_abort_idle");
    rand_bytes(3);
    seg_misalign("misalign", 5);
    fb_q = '{8'h5A, 8'hC3, 8'h81, 8'hE7};
    seg_good("after_misalign", 1);
    fb_q = '{8'hAA, 8'h55};
    seg_good("short", 3);
    fb_q = '{8'h3C};
    seg_good("one_byte", 1);

    // Reset in the middle of a frame: the partial frame is lost silently.
    fb_q = '{8'hC3, 8'h5A};
    add_flag();
    add_bytes();
    for (int i = 0; i < 4; i++) bits_q.push_back(1'($urandom_range(0, 1)));
    send_bits();
    chk("mid.active", RxActive, 1'b1);
    exp_data(1, 1'b0);
    check_events("mid");
    Rstn = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    repeat (3) @(negedge Clk);
    chk_reset_outputs("mid_reset_hold");
    Rstn = 1'b1;
    fb_q = '{8'h12, 8'h34, 8'h56, 8'h78};
    seg_good("after_reset", 1);

    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 3))
        0: begin rand_bytes($urandom_range(1, 4)); seg_abort($sformatf("r%0d.abort", it)); end
        1: begin rand_bytes($urandom_range(1, 4)); seg_misalign($sformatf("r%0d.mis", it), $urandom_range(1, 7)); end
        default: begin rand_bytes($urandom_range(1, 7)); seg_good($sformatf("r%0d.good", it), $urandom_range(1, 2)); end
      endcase
    end

    chk("stray_strobes", bad_strobes, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
